// File: rtl/w_writeback.sv
// Write-back stage: M/W pipeline register, load-data extension, result select and retire counter.
// Define WB_TRACE_EN to print a simulation trace line for each GRF write.
module w_writeback #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             M_valid,
    input  logic [31:0]      M_pc,
    input  logic             M_reg_we,
    input  logic [4:0]       M_rd,
    input  logic [1:0]       M_wb_sel,
    input  logic [31:0]      M_alu_res,
    input  logic [31:0]      M_hilo,
    input  logic [31:0]      M_mem_rdata,
    input  logic [2:0]       M_load_type,
    output logic [31:0]      W_pc,
    output logic             W_we,
    output logic [4:0]       W_A3,
    output logic [31:0]      W_WD,
    output logic [CNT_W-1:0] retire_cnt
);

    typedef enum logic [1:0] {
        SEL_ALU  = 2'd0,
        SEL_MEM  = 2'd1,
        SEL_LINK = 2'd2,
        SEL_HILO = 2'd3
    } wb_sel_t;

    typedef enum logic [2:0] {
        LD_W  = 3'd0,
        LD_B  = 3'd1,
        LD_BU = 3'd2,
        LD_H  = 3'd3,
        LD_HU = 3'd4
    } load_t;

    logic        w_valid;
    logic [31:0] w_pc_reg;
    logic        w_reg_we;
    logic [4:0]  w_rd;
    logic [1:0]  w_wb_sel;
    logic [31:0] w_alu_res;
    logic [31:0] w_hilo;
    logic [31:0] w_rdata;
    logic [2:0]  w_load_type;

    always_ff @(posedge clk) begin
        if (reset) begin
            w_valid     <= 1'b0;
            w_pc_reg    <= PC_RESET;
            w_reg_we    <= 1'b0;
            w_rd        <= '0;
            w_wb_sel    <= '0;
            w_alu_res   <= '0;
            w_hilo      <= '0;
            w_rdata     <= '0;
            w_load_type <= '0;
            retire_cnt  <= '0;
        end else begin
            w_valid     <= M_valid;
            w_pc_reg    <= M_pc;
            w_reg_we    <= M_reg_we;
            w_rd        <= M_rd;
            w_wb_sel    <= M_wb_sel;
            w_alu_res   <= M_alu_res;
            w_hilo      <= M_hilo;
            w_rdata     <= M_mem_rdata;
            w_load_type <= M_load_type;
            if (M_valid)
                retire_cnt <= retire_cnt + CNT_W'(1);
        end
    end

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic [31:0] wd_sel;

    always_comb begin
        ld_byte = w_rdata[7:0];
        case (w_alu_res[1:0])
            2'd0: ld_byte = w_rdata[7:0];
            2'd1: ld_byte = w_rdata[15:8];
            2'd2: ld_byte = w_rdata[23:16];
            2'd3: ld_byte = w_rdata[31:24];
            default: ld_byte = w_rdata[7:0];
        endcase
        // Half select uses only offset bit 1; misaligned halves are trapped upstream.
        ld_half = w_alu_res[1] ? w_rdata[31:16] : w_rdata[15:0];

        ld_data = w_rdata;
        case (w_load_type)
            LD_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            LD_BU:   ld_data = {24'd0, ld_byte};
            LD_H:    ld_data = {{16{ld_half[15]}}, ld_half};
            LD_HU:   ld_data = {16'd0, ld_half};
            default: ld_data = w_rdata;
        endcase

        wd_sel = w_alu_res;
        case (w_wb_sel)
            SEL_ALU:  wd_sel = w_alu_res;
            SEL_MEM:  wd_sel = ld_data;
            SEL_LINK: wd_sel = w_pc_reg + 32'd8;
            SEL_HILO: wd_sel = w_hilo;
            default:  wd_sel = w_alu_res;
        endcase
    end

    assign W_we = w_valid & w_reg_we & (w_rd != 5'd0);
    assign W_A3 = w_valid ? w_rd : '0;
    assign W_WD = w_valid ? wd_sel : '0;
    assign W_pc = w_valid ? w_pc_reg : PC_RESET;

`ifdef WB_TRACE_EN
    always @(posedge clk) begin
        if (!reset && W_we)
            $display("@%08h: $%2d <= %08h", W_pc, W_A3, W_WD);
    end
`endif

endmodule
